// File: rtl/tap_delay_line_pkg.sv
// rtl/tap_delay_line_pkg.sv - shared types and helpers for tap_delay_line (BIST option: TAP_DELAY_LINE_BIST_EN)
package tap_delay_line_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } bist_state_e;

  // Out-of-range tap requests saturate at the last stage.
  function automatic int clamp_tap(input int tap, input int depth);
    return (tap >= depth) ? (depth - 1) : tap;
  endfunction

  // Highest count WAIT reaches before declaring that no pulse arrived.
  function automatic int bist_timeout(input int depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/tap_delay_line_if.sv
// rtl/tap_delay_line_if.sv - lane data, tap config and BIST signals of tap_delay_line
interface tap_delay_line_if #(
  parameter int CHANNELS = 8,
  parameter int TAPW     = 6,
  parameter int CW       = 7
);
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] dout;
  logic                cfg_we;
  logic [TAPW-1:0]     cfg_tap;
  logic                bist_start;
  logic                bist_busy;
  logic                bist_done;
  logic                bist_pass;
  logic [CW-1:0]       bist_count;

  modport master (
    output din, cfg_we, cfg_tap, bist_start,
    input  dout, bist_busy, bist_done, bist_pass, bist_count
  );

  modport slave (
    input  din, cfg_we, cfg_tap, bist_start,
    output dout, bist_busy, bist_done, bist_pass, bist_count
  );
endinterface

// File: rtl/tap_delay_line_delay_lane.sv
// rtl/tap_delay_line_delay_lane.sv - one lane: DEPTH-stage shift register with tap mux
module delay_lane #(
  parameter int DEPTH = 64,
  parameter int TAPW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            d,
  input  logic [TAPW-1:0] tap,
  output logic            q
);

  logic [DEPTH-1:0] stage;

  // Shift a new sample into stage[0] every cycle; stage[k] is the input from k+1 edges ago.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage <= (stage << 1) | DEPTH'(d);
    end
  end

  // Tap is clamped upstream, so it always addresses an existing stage.
  assign q = stage[tap];

endmodule

// File: rtl/tap_delay_line.sv
// rtl/tap_delay_line.sv - multi-lane tap-selectable delay line with optional BIST (TAP_DELAY_LINE_BIST_EN)
module tap_delay_line
  import tap_delay_line_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int DEPTH    = 64,
  parameter int TAPW     = $clog2(DEPTH),
  parameter int CW       = $clog2(DEPTH + 2)
) (
  input  logic            clk,
  input  logic            rst_n,
  tap_delay_line_if.slave bus
);

  logic [TAPW-1:0]     tap_q;
  logic [CHANNELS-1:0] lane_d;
  logic [CHANNELS-1:0] lane_q;
  logic                busy;

  // Tap register: lane contents are untouched, so a new tap realigns output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q <= '0;
    end else if (bus.cfg_we && !busy) begin
      tap_q <= TAPW'(clamp_tap(int'(bus.cfg_tap), DEPTH));
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    delay_lane #(
      .DEPTH (DEPTH),
      .TAPW  (TAPW)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (lane_d[i]),
      .tap   (tap_q),
      .q     (lane_q[i])
    );
  end

  assign bus.dout = lane_q;

`ifdef TAP_DELAY_LINE_BIST_EN

  localparam logic [CW-1:0] FLUSH_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] TIMEOUT    = CW'(bist_timeout(DEPTH));

  bist_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] count_q;
  logic          pass_q;
  logic          inject;
  logic          done;
  logic          any_hit;
  logic          all_hit;
  logic [CW-1:0] tap_plus1;

  assign any_hit   = |lane_q;
  assign all_hit   = &lane_q;
  assign tap_plus1 = CW'(tap_q) + CW'(1);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, injected lane value and status strobes.
  always_comb begin
    state_d = state_q;
    inject  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.bist_start) state_d = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (cnt_q == FLUSH_LAST) state_d = LAUNCH;
      end
      LAUNCH: begin
        busy    = 1'b1;
        inject  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (any_hit || (cnt_q == TIMEOUT)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Cycle counter (flush length, then arrival time) and the held test result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      count_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE:   cnt_q <= '0;
        FLUSH:  cnt_q <= cnt_q + CW'(1);
        LAUNCH: cnt_q <= CW'(1);
        WAIT: begin
          if (any_hit) begin
            count_q <= cnt_q;
            pass_q  <= all_hit && (cnt_q == tap_plus1);
          end else if (cnt_q == TIMEOUT) begin
            count_q <= cnt_q;
            pass_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign lane_d         = (state_q == IDLE) ? bus.din : {CHANNELS{inject}};
  assign bus.bist_busy  = busy;
  assign bus.bist_done  = done;
  assign bus.bist_pass  = pass_q;
  assign bus.bist_count = count_q;

`else

  logic unused_bist_start;

  assign unused_bist_start = bus.bist_start;
  assign busy              = 1'b0;
  assign lane_d            = bus.din;
  assign bus.bist_busy     = 1'b0;
  assign bus.bist_done     = 1'b0;
  assign bus.bist_pass     = 1'b0;
  assign bus.bist_count    = {CW{1'b0}};

`endif

endmodule
